// File: rtl/camera_capture_rgb565.sv
// camera_capture_rgb565
// Turns the camera's 8-bit RGB565 byte stream (vsync/href/d, high byte first) into
// 16-bit raster-order pixel writes for the frame buffer's write port. Pixels beyond
// H_PIX columns or V_PIX lines are dropped, and their presence is flagged on `clipped`.
//
// Ports:
//   clk, rst    camera pixel clock; synchronous active-high reset
//   capture_en  arms capture; only looked at on frame boundaries
//   vsync       high = vertical blanking
//   href        high = valid byte on d
//   d           camera data byte
//   addr_in     RAM write address (holds while regwrite = 0)
//   data_in     RAM write data    (holds while regwrite = 0)
//   regwrite    one-cycle write strobe per accepted pixel
//   frame_done  one-cycle pulse after vsync is seen at the end of a captured frame
//   clipped     sticky: the frame overflowed the configured window

module camera_capture_rgb565 #(
   parameter int unsigned H_PIX = 160,
   parameter int unsigned V_PIX = 120,
   parameter int unsigned AW    = 17,
   parameter int unsigned DW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          capture_en,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    d,
   output logic [AW-1:0] addr_in,
   output logic [DW-1:0] data_in,
   output logic          regwrite,
   output logic          frame_done,
   output logic          clipped
);

   // Counters reach H_PIX / V_PIX inclusive so "limit reached" is representable.
   localparam int unsigned CW = $clog2(H_PIX + 1);
   localparam int unsigned RW = $clog2(V_PIX + 1);

   localparam logic [CW-1:0] ColLim  = CW'(H_PIX);
   localparam logic [RW-1:0] RowLim  = RW'(V_PIX);
   localparam logic [AW-1:0] RowStep = AW'(H_PIX);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StSync    = 2'd1;
   localparam logic [1:0] StCapture = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic [AW-1:0] row_base_q;
   logic          phase_q;
   logic [7:0]    hi_q;
   logic          href_q;     // previous href, for falling-edge detection
   logic          line_pix_q; // current line has produced a complete pixel

   logic start_frame;
   logic pix_ok;

   assign start_frame = (state_q == StSync) && !vsync;
   assign pix_ok      = (col_q < ColLim) && (row_q < RowLim);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (capture_en && vsync) state_d = StSync;
         StSync:    if (!vsync) state_d = StCapture;
         StCapture: if (vsync) state_d = capture_en ? StSync : StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_in    <= '0;
         data_in    <= '0;
         regwrite   <= 1'b0;
         frame_done <= 1'b0;
         clipped    <= 1'b0;
         col_q      <= '0;
         row_q      <= '0;
         row_base_q <= '0;
         phase_q    <= 1'b0;
         hi_q       <= '0;
         href_q     <= 1'b0;
         line_pix_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         regwrite   <= 1'b0;
         frame_done <= 1'b0;
         href_q     <= 1'b0;

         if (start_frame) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            phase_q    <= 1'b0;
            clipped    <= 1'b0;
            line_pix_q <= 1'b0;
         end else if (state_q == StCapture) begin
            if (vsync) begin
               // End of frame: any half-assembled pixel is simply abandoned.
               frame_done <= 1'b1;
               phase_q    <= 1'b0;
               line_pix_q <= 1'b0;
            end else begin
               href_q <= href;
               if (href) begin
                  phase_q <= ~phase_q;
                  if (!phase_q) begin
                     hi_q <= d;
                  end else begin
                     line_pix_q <= 1'b1;
                     if (pix_ok) begin
                        addr_in  <= row_base_q + AW'(col_q);
                        data_in  <= DW'({hi_q, d});
                        regwrite <= 1'b1;
                        col_q    <= col_q + 1'b1;
                     end else begin
                        clipped <= 1'b1;
                     end
                  end
               end else if (href_q) begin
                  // Line end: drop an odd trailing byte, advance only if the line had pixels.
                  phase_q <= 1'b0;
                  if (line_pix_q) begin
                     col_q      <= '0;
                     line_pix_q <= 1'b0;
                     if (row_q < RowLim) begin
                        row_q      <= row_q + 1'b1;
                        row_base_q <= row_base_q + RowStep;
                     end
                  end
               end
            end
         end
      end
   end

endmodule
